dv_checkpoint_monitor: RTL and testbench

Parametrised checkpoint-sequence monitor for user-project verification on the Caravel `mprj_io` checkbits. It watches a WIDTH-bit checkbits bus for an ordered list of up to DEPTH masked signature values. Each value must be held stable for STABLE cycles before it counts. Each step has a programmable timeout. The result is reported as sticky pass/fail with the failing step index. The block is synthesisable: it can sit in the user project area on `wb_clk_i` to self-check logic-analyzer and GPIO tests, or be instantiated by testbenches in place of hand-written wait chains.

---
 rtl/dv_ckpt_pkg.sv | 22 ++
 rtl/ckpt_stab_filter.sv | 41 ++++
 rtl/dv_checkpoint_monitor.sv | 140 ++++++++++++++
 tb/tb_dv_checkpoint_monitor.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dv_ckpt_pkg.sv
// Shared types and default parameters for the checkpoint-sequence monitor.
package dv_ckpt_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_STABLE = 2;
  localparam int DEF_TMO_W  = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } ckpt_state_e;

  // Table entry layout at the default width; the top re-declares it at WIDTH.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] value;
    logic [DEF_WIDTH-1:0] mask;
  } ckpt_entry_t;

endpackage

// File: rtl/ckpt_stab_filter.sv
// Registers the observed bus once and qualifies a masked match that must hold
// unchanged for STABLE consecutive cycles before done pulses.
module ckpt_stab_filter
  import dv_ckpt_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STABLE = DEF_STABLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] checkbits,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] mask,
  input  logic             clear,
  output logic             done
);

  localparam int SW = (STABLE > 1) ? $clog2(STABLE) : 1;

  logic [WIDTH-1:0] sample_q;
  logic [SW-1:0]    stab_cnt;
  logic             match;
  logic             changed;

  assign match   = ((sample_q ^ value) & mask) == '0;
  assign changed = checkbits != sample_q;
  assign done    = !clear && match && (stab_cnt == SW'(STABLE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
      stab_cnt <= '0;
    end else begin
      sample_q <= checkbits;
      // A new sample value restarts the count even if it still matches under the mask.
      if (clear || changed || !match || done) stab_cnt <= '0;
      else                                    stab_cnt <= stab_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dv_checkpoint_monitor.sv
// Checkpoint-sequence monitor: ordered masked signatures on checkbits_i, sticky pass/fail.
// The per-step timeout exists only when CKPT_MON_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | nothing run since reset
// ARMED | walking the table, busy_o=1
// PASS  | all active steps matched in order
// FAIL  | current step exceeded its timeout
module dv_checkpoint_monitor
  import dv_ckpt_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int STABLE = DEF_STABLE,
  parameter int TMO_W  = DEF_TMO_W,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] checkbits_i,
  input  logic             cfg_we_i,
  input  logic [AW-1:0]    cfg_addr_i,
  input  logic [WIDTH-1:0] cfg_value_i,
  input  logic [WIDTH-1:0] cfg_mask_i,
  input  logic [AW:0]      cfg_len_i,
  input  logic [TMO_W-1:0] tmo_limit_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic [AW-1:0]    step_o,
  output logic             match_pulse_o
);

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] mask;
  } entry_t;

  entry_t      tbl_q [DEPTH];
  ckpt_state_e state_q, state_n;
  logic [AW:0] len_q, len_in;
  logic        done, last, tmo_hit, start_ok;

  assign len_in   = (cfg_len_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_len_i;
  assign last     = {1'b0, step_o} == (len_q - 1'b1);
  assign start_ok = start_i && (state_q != ARMED);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '{value: '0, mask: '1};
    end else if (cfg_we_i && !busy_o) begin
      tbl_q[cfg_addr_i] <= '{value: cfg_value_i, mask: cfg_mask_i};
    end
  end

  ckpt_stab_filter #(.WIDTH(WIDTH), .STABLE(STABLE)) u_filter (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .checkbits (checkbits_i),
    .value     (tbl_q[step_o].value),
    .mask      (tbl_q[step_o].mask),
    .clear     (state_q != ARMED),
    .done      (done)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_n;
  end

  // Completion takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE, PASS, FAIL: if (start_i) state_n = (len_in == '0) ? PASS : ARMED;
      ARMED: begin
        if (done) begin
          if (last) state_n = PASS;
        end else if (tmo_hit) begin
          state_n = FAIL;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      busy_o        <= 1'b0;
      pass_o        <= 1'b0;
      step_o        <= '0;
      match_pulse_o <= 1'b0;
      len_q         <= '0;
    end else begin
      busy_o        <= state_n == ARMED;
      pass_o        <= state_n == PASS;
      match_pulse_o <= done;
      if (start_ok) begin
        step_o <= '0;
        len_q  <= len_in;
      end else if (done && !last) begin
        step_o <= step_o + 1'b1;
      end
    end
  end

`ifdef CKPT_MON_TIMEOUT_EN
  logic [TMO_W-1:0] limit_q, tmo_left;
  logic             fail_q;

  // Down-counter reloaded to limit-1 on step entry; terminal count at zero.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      limit_q  <= '0;
      tmo_left <= '0;
      fail_q   <= 1'b0;
    end else begin
      fail_q <= state_n == FAIL;
      if (start_ok) begin
        limit_q  <= tmo_limit_i;
        tmo_left <= tmo_limit_i - 1'b1;
      end else if (done) begin
        tmo_left <= limit_q - 1'b1;
      end else if (state_q == ARMED && tmo_left != '0) begin
        tmo_left <= tmo_left - 1'b1;
      end
    end
  end

  assign tmo_hit = (state_q == ARMED) && (limit_q != '0) && (tmo_left == '0);
  assign fail_o  = fail_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^tmo_limit_i;
  assign tmo_hit    = 1'b0;
  assign fail_o     = 1'b0;
`endif

endmodule

// File: tb/tb_dv_checkpoint_monitor.sv
// Self-checking bench for dv_checkpoint_monitor: directed scenarios plus random traffic
// checked every cycle against a window-based behavioural model.
module tb_dv_checkpoint_monitor;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 4;
  localparam int STABLE = 2;
  localparam int TMO_W  = 24;
  localparam int AW     = 2;
  localparam int S_IDLE = 0, S_RUN = 1, S_PASS = 2, S_FAIL = 3;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i;
  logic [WIDTH-1:0] checkbits_i;
  logic             cfg_we_i;
  logic [AW-1:0]    cfg_addr_i;
  logic [WIDTH-1:0] cfg_value_i, cfg_mask_i;
  logic [AW:0]      cfg_len_i;
  logic [TMO_W-1:0] tmo_limit_i;
  logic             start_i;
  logic             busy_o, pass_o, fail_o, match_pulse_o;
  logic [AW-1:0]    step_o;

  always #5 wb_clk_i = ~wb_clk_i;

  dv_checkpoint_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STABLE(STABLE), .TMO_W(TMO_W)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .checkbits_i(checkbits_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_value_i(cfg_value_i),
    .cfg_mask_i(cfg_mask_i), .cfg_len_i(cfg_len_i), .tmo_limit_i(tmo_limit_i),
    .start_i(start_i), .busy_o(busy_o), .pass_o(pass_o), .fail_o(fail_o),
    .step_o(step_o), .match_pulse_o(match_pulse_o)
  );

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  bit chk_en = 1'b0;

  // Model: a step completes when the last STABLE samples taken since the step
  // began are identical and match the entry; timeout is limit cycles after entry.
  logic [WIDTH-1:0] m_val [DEPTH];
  logic [WIDTH-1:0] m_msk [DEPTH];
  logic [WIDTH-1:0] hist [64];
  int edge_n = 0, m_st = S_IDLE, m_step = 0, m_len = 0, m_entry = 0, m_limit = 0;
  logic e_busy = 1'b0, e_pass = 1'b0, e_fail = 1'b0, e_pulse = 1'b0;
  int e_step = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit window_ok();
    logic [WIDTH-1:0] v0;
    if (edge_n - STABLE < m_entry) return 1'b0;
    v0 = hist[(edge_n - 1) % 64];
    for (int i = 1; i <= STABLE; i++)
      if (hist[(edge_n - i) % 64] != v0) return 1'b0;
    return ((v0 ^ m_val[m_step]) & m_msk[m_step]) == '0;
  endfunction

  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      m_st = S_IDLE; m_step = 0; e_pulse = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin m_val[i] = '0; m_msk[i] = '1; end
      chk_en = 1'b1;
    end else begin
      e_pulse = 1'b0;
      if (m_st == S_RUN) begin
        if (window_ok()) begin
          e_pulse = 1'b1;
          if (m_step == m_len - 1) m_st = S_PASS;
          else begin m_step++; m_entry = edge_n; end
        end
`ifdef CKPT_MON_TIMEOUT_EN
        else if (m_limit != 0 && edge_n == m_entry + m_limit) m_st = S_FAIL;
`endif
      end else if (start_i) begin
        m_len   = (int'(cfg_len_i) > DEPTH) ? DEPTH : int'(cfg_len_i);
        m_limit = int'(tmo_limit_i);
        m_step  = 0;
        m_entry = edge_n;
        m_st    = (m_len == 0) ? S_PASS : S_RUN;
      end
      if (cfg_we_i && !e_busy) begin
        m_val[cfg_addr_i] = cfg_value_i;
        m_msk[cfg_addr_i] = cfg_mask_i;
      end
    end
    e_busy = (m_st == S_RUN);
    e_pass = (m_st == S_PASS);
    e_fail = (m_st == S_FAIL);
    e_step = m_step;
    hist[edge_n % 64] = checkbits_i;
    edge_n++;
  end

  always begin
    @(posedge wb_clk_i); #1;
    if (chk_en) begin
      chk("busy_o", 32'(busy_o), 32'(e_busy));
      chk("pass_o", 32'(pass_o), 32'(e_pass));
      chk("fail_o", 32'(fail_o), 32'(e_fail));
      chk("step_o", 32'(step_o), 32'(e_step));
      chk("match_pulse_o", 32'(match_pulse_o), 32'(e_pulse));
    end
  end

  always begin
    @(posedge wb_clk_i); #1;
    if (match_pulse_o === 1'b1) pulse_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic wr(input int a, input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] m);
    cfg_we_i = 1'b1; cfg_addr_i = AW'(a); cfg_value_i = v; cfg_mask_i = m;
    cyc(1);
    cfg_we_i = 1'b0;
  endtask

  task automatic do_start(input int len, input int lim);
    start_i = 1'b1; cfg_len_i = (AW+1)'(len); tmo_limit_i = TMO_W'(lim);
    cyc(1);
    start_i = 1'b0;
  endtask

  task automatic wait_pulse(input int max_n, output int n);
    n = 0;
    do begin cyc(1); n++; end while (match_pulse_o !== 1'b1 && n < max_n);
    chk("pulse_seen", 32'(match_pulse_o), 32'd1);
  endtask

  function automatic logic [WIDTH-1:0] pick_val();
    case ($urandom_range(0, 4))
      0: return 16'hAB40;
      1: return 16'hAB41;
      2: return 16'h1234;
      3: return 16'h0000;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] pick_mask();
    case ($urandom_range(0, 3))
      0: return 16'hFF00;
      1: return 16'h00F0;
      2: return WIDTH'($urandom);
      default: return 16'hFFFF;
    endcase
  endfunction

  initial begin
    int n, f, r, idx;
    wb_rst_i = 1'b1; checkbits_i = '0; cfg_we_i = 1'b0; cfg_addr_i = '0;
    cfg_value_i = '0; cfg_mask_i = '0; cfg_len_i = '0; tmo_limit_i = '0; start_i = 1'b0;
    cyc(3);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_pass", 32'(pass_o), 32'd0);
    chk("rst_fail", 32'(fail_o), 32'd0);
    chk("rst_step", 32'(step_o), 32'd0);
    chk("rst_pulse", 32'(match_pulse_o), 32'd0);
    wb_rst_i = 1'b0;
    cyc(1);

    // three-step sequence to pass
    wr(0, 16'hAB40, 16'hFFFF); wr(1, 16'hAB41, 16'hFFFF); wr(2, 16'hAB51, 16'hFFFF);
    pulse_cnt = 0;
    do_start(3, 1000);
    checkbits_i = 16'hAB40; cyc(5);
    checkbits_i = 16'hAB41; cyc(5);
    checkbits_i = 16'hAB51; cyc(5);
    checkbits_i = 16'h0000; cyc(2);
    chk("seq_pulses", 32'(pulse_cnt), 32'd3);
    chk("seq_pass", 32'(pass_o), 32'd1);
    chk("seq_step", 32'(step_o), 32'd2);
    chk("seq_busy", 32'(busy_o), 32'd0);
    chk("model_seq_pass", 32'(e_pass), 32'd1);
    chk("model_seq_step", 32'(e_step), 32'd2);

    // short glitch then held value: pulse on third edge
    pulse_cnt = 0;
    do_start(3, 1000);
    checkbits_i = 16'hAB40; cyc(1);
    checkbits_i = 16'h0000; cyc(4);
    chk("glitch_no_pulse", 32'(pulse_cnt), 32'd0);
    checkbits_i = 16'hAB40;
    wait_pulse(20, n);
    chk("stable_latency", 32'(n), 32'd3);
    checkbits_i = 16'hAB41; cyc(4);
    checkbits_i = 16'hAB51; cyc(4);
    chk("glitch_seq_pass", 32'(pass_o), 32'd1);

    // stuck step 1 with limit 50
    do_start(3, 50);
    checkbits_i = 16'hAB40;
    wait_pulse(20, n);
    checkbits_i = 16'h0000;
`ifdef CKPT_MON_TIMEOUT_EN
    f = 0;
    while (fail_o !== 1'b1 && f < 200) begin cyc(1); f++; end
    chk("tmo_cycles", 32'(f), 32'd50);
    chk("tmo_fail", 32'(fail_o), 32'd1);
    chk("tmo_step", 32'(step_o), 32'd1);
    chk("tmo_busy", 32'(busy_o), 32'd0);
    chk("model_tmo_fail", 32'(e_fail), 32'd1);
`else
    cyc(60);
    chk("notmo_fail", 32'(fail_o), 32'd0);
    chk("notmo_busy", 32'(busy_o), 32'd1);
`endif

    // masked compare and write dropped while busy
    wb_rst_i = 1'b1; cyc(2); wb_rst_i = 1'b0;
    wr(0, 16'hAB00, 16'hFF00); wr(1, 16'h1234, 16'hFFFF);
    do_start(2, 0);
    checkbits_i = 16'hAB7F;
    wait_pulse(20, n);
    chk("mask_step", 32'(step_o), 32'd1);
    wr(1, 16'h5555, 16'hFFFF);
    checkbits_i = 16'h1234;
    wait_pulse(20, n);
    chk("mask_pass", 32'(pass_o), 32'd1);
    do_start(2, 0);
    checkbits_i = 16'hAB7F; wait_pulse(20, n);
    checkbits_i = 16'h1234; wait_pulse(20, n);
    chk("readback_pass", 32'(pass_o), 32'd1);

    // len 0, ignored start, reset mid-run
    do_start(0, 0);
    chk("len0_pass", 32'(pass_o), 32'd1);
    chk("len0_pulse", 32'(match_pulse_o), 32'd0);
    chk("len0_busy", 32'(busy_o), 32'd0);
    do_start(2, 0);
    chk("armed_busy", 32'(busy_o), 32'd1);
    checkbits_i = 16'hAB7F; wait_pulse(20, n);
    do_start(0, 0);
    chk("ign_busy", 32'(busy_o), 32'd1);
    chk("ign_pass", 32'(pass_o), 32'd0);
    chk("ign_step", 32'(step_o), 32'd1);
    wb_rst_i = 1'b1; cyc(1);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_pass", 32'(pass_o), 32'd0);
    chk("abort_fail", 32'(fail_o), 32'd0);
    chk("abort_step", 32'(step_o), 32'd0);
    chk("abort_pulse", 32'(match_pulse_o), 32'd0);
    wb_rst_i = 1'b0;

    // stuck input, limit 10
    do_start(2, 10);
    checkbits_i = 16'hFFFF;
`ifdef CKPT_MON_TIMEOUT_EN
    cyc(20);
    chk("stuck_fail", 32'(fail_o), 32'd1);
    chk("stuck_step", 32'(step_o), 32'd0);
`else
    cyc(1000);
    chk("stuck_nofail", 32'(fail_o), 32'd0);
    chk("stuck_busy", 32'(busy_o), 32'd1);
`endif
    wb_rst_i = 1'b1; cyc(2); wb_rst_i = 1'b0;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      wb_rst_i    = ($urandom_range(0, 399) == 0);
      start_i     = ($urandom_range(0, 24) == 0);
      cfg_len_i   = (AW+1)'($urandom_range(0, 7));
      tmo_limit_i = TMO_W'($urandom_range(0, 40));
      cfg_we_i    = ($urandom_range(0, 9) == 0);
      cfg_addr_i  = AW'($urandom_range(0, DEPTH - 1));
      cfg_value_i = pick_val();
      cfg_mask_i  = pick_mask();
      r = $urandom_range(0, 9);
      if (r >= 6 && r < 9) begin
        idx = $urandom_range(0, DEPTH - 1);
        checkbits_i = (m_val[idx] & m_msk[idx]) | (WIDTH'($urandom) & ~m_msk[idx]);
      end else if (r == 9) begin
        checkbits_i = pick_val();
      end
      cyc(1);
    end
    wb_rst_i = 1'b0; start_i = 1'b0; cfg_we_i = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
